// File: rtl/mem_arbiter_pkg.sv
// Shared LC-3b types for the memory arbiter slice.
// Holds the arbiter state encoding and the latched request bundle.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } arb_state_t;

  typedef struct packed {
    lc3b_word      addr;
    lc3b_word      wdata;
    lc3b_mem_wmask wmask;
    logic          read;
    logic          write;
  } arb_req_t;

endpackage

// File: rtl/mem_arbiter_streak_counter.sv
// Saturating count of D grants issued while a fetch waits.
// at_max_o tells the arbiter the fetch port must win next.
module arb_streak_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q < MAX_V))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign at_max_o = (cnt_q >= MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one physical memory port.
// D has priority; a streak limit keeps fetch moving.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int STREAK_W     = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_read,
  input  lc3b_word      i_address,
  output lc3b_word      i_rdata,
  output logic          i_resp,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_word      d_address,
  input  lc3b_word      d_wdata,
  input  lc3b_mem_wmask d_wmask,
  output lc3b_word      d_rdata,
  output logic          d_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_wmask,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp
);

  arb_state_t state_q;
  arb_req_t   req_q;
  arb_req_t   d_req_s;
  lc3b_word   i_rdata_q;
  lc3b_word   d_rdata_q;
  logic       i_resp_q;
  logic       d_resp_q;

  logic d_req;
  logic at_max;
  logic grant_d;
  logic grant_i;
  logic s_inc;
  logic s_clr;

  // Grant decision and the D request as it would be latched.
  always_comb begin
    d_req   = d_read | d_write;
    grant_d = (state_q == IDLE) && d_req && (!i_read || !at_max);
    grant_i = (state_q == IDLE) && !grant_d && i_read;
    s_inc   = grant_d && i_read;
    s_clr   = grant_i || (grant_d && !i_read);
    d_req_s = '{
      addr:  d_address,
      wdata: d_wdata,
      wmask: d_wmask,
      read:  d_read & ~d_write,
      write: d_write
    };
  end

  arb_streak_counter #(
    .MAX (MAX_D_STREAK),
    .W   (STREAK_W)
  ) u_streak (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc_i    (s_inc),
    .clr_i    (s_clr),
    .at_max_o (at_max)
  );

  // Arbiter FSM; strobes, rdata and resp are all registered here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            req_q   <= d_req_s;
            state_q <= BUSY_D;
          end else if (grant_i) begin
            req_q.addr  <= i_address;
            req_q.wmask <= 2'b11;
            req_q.read  <= 1'b1;
            req_q.write <= 1'b0;
            state_q     <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (pmem_resp) begin
            i_rdata_q   <= pmem_rdata;
            i_resp_q    <= 1'b1;
            req_q.read  <= 1'b0;
            req_q.write <= 1'b0;
            state_q     <= DONE_I;
          end
        end
        BUSY_D: begin
          if (pmem_resp) begin
            d_rdata_q   <= pmem_rdata;
            d_resp_q    <= 1'b1;
            req_q.read  <= 1'b0;
            req_q.write <= 1'b0;
            state_q     <= DONE_D;
          end
        end
        DONE_I, DONE_D: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_rdata      = i_rdata_q;
  assign i_resp       = i_resp_q;
  assign d_rdata      = d_rdata_q;
  assign d_resp       = d_resp_q;
  assign pmem_read    = req_q.read;
  assign pmem_write   = req_q.write;
  assign pmem_address = req_q.addr;
  assign pmem_wdata   = req_q.wdata;
  assign pmem_wmask   = req_q.wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable memory.
// Expected values are hand-derived from the arbiter's timing rules.
module tb_mem_arbiter;
  import lc3b_types::*;

  logic        clk;
  logic        reset_n;
  logic        i_read;
  logic [15:0] i_address;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic [1:0]  d_wmask;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int mcnt = 0;
  logic force_resp = 1'b0;

  mem_arbiter #(
    .MAX_D_STREAK (4),
    .STREAK_W     (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_wmask      (d_wmask),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_wmask   (pmem_wmask),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: raise resp in the lat-th cycle of a held strobe.
  always @(negedge clk) begin
    if (pmem_read || pmem_write) begin
      mcnt = mcnt + 1;
      pmem_resp = force_resp || (mcnt == lat);
    end else begin
      mcnt = 0;
      pmem_resp = force_resp;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int nd;
    int first_i;
    int maxc;
    int both;
    logic [1:0] lg [0:19];

    pmem_resp  = 1'b0;
    reset_n    = 1'b0;
    i_read     = 1'b1;
    i_address  = 16'h3000;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = 16'h0;
    d_wdata    = 16'h0;
    d_wmask    = 2'b00;
    pmem_rdata = 16'h1234;
    lat        = 3;

    // Reset held two cycles with a fetch pending.
    tick();
    tick();
    chk("rst_pmem_read", {15'd0, pmem_read}, 16'd0);
    chk("rst_pmem_write", {15'd0, pmem_write}, 16'd0);
    chk("rst_addr", pmem_address, 16'h0);
    chk("rst_wdata", pmem_wdata, 16'h0);
    chk("rst_wmask", {14'd0, pmem_wmask}, 16'd0);
    chk("rst_resp", {14'd0, i_resp, d_resp}, 16'd0);
    chk("rst_i_rdata", i_rdata, 16'h0);
    chk("rst_d_rdata", d_rdata, 16'h0);

    // Release: fetch granted one cycle later.
    reset_n = 1'b1;
    tick();
    chk("rel_pmem_read", {15'd0, pmem_read}, 16'd1);
    chk("rel_addr", pmem_address, 16'h3000);
    chk("rel_wmask", {14'd0, pmem_wmask}, 16'd3);

    // Single fetch, latency 3.
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (i_resp) break;
      if (pmem_read) n++;
      tick();
    end
    chk("fetch_strobe_cycles", 16'(n), 16'd3);
    chk("fetch_i_resp", {15'd0, i_resp}, 16'd1);
    chk("fetch_i_rdata", i_rdata, 16'h1234);
    chk("fetch_strobe_drop", {15'd0, pmem_read}, 16'd0);
    i_read = 1'b0;
    tick();
    chk("fetch_resp_pulse", {15'd0, i_resp}, 16'd0);
    chk("fetch_rdata_hold", i_rdata, 16'h1234);
    chk("fetch_idle", 16'(dut.state_q), 16'(IDLE));

    // Simultaneous fetch and byte store: D first.
    lat        = 1;
    pmem_rdata = 16'h5555;
    i_read     = 1'b1;
    i_address  = 16'h3002;
    d_write    = 1'b1;
    d_address  = 16'h4000;
    d_wdata    = 16'hBEEF;
    d_wmask    = 2'b01;
    tick();
    chk("sim_d_write", {14'd0, pmem_read, pmem_write}, 16'd1);
    chk("sim_d_addr", pmem_address, 16'h4000);
    chk("sim_d_wdata", pmem_wdata, 16'hBEEF);
    chk("sim_d_wmask", {14'd0, pmem_wmask}, 16'd1);
    tick();
    chk("sim_d_resp", {14'd0, i_resp, d_resp}, 16'd1);
    chk("sim_d_rdata", d_rdata, 16'h5555);
    d_write = 1'b0;
    tick();
    chk("sim_done_idle", {14'd0, pmem_read, pmem_write}, 16'd0);
    pmem_rdata = 16'h6666;
    tick();
    chk("sim_i_read", {14'd0, pmem_read, pmem_write}, 16'd2);
    chk("sim_i_addr", pmem_address, 16'h3002);
    tick();
    chk("sim_i_resp", {14'd0, i_resp, d_resp}, 16'd2);
    chk("sim_i_rdata", i_rdata, 16'h6666);
    i_read = 1'b0;
    tick();

    // Fairness: D streams, I held; I wins after four D grants.
    d_read    = 1'b1;
    d_address = 16'h5000;
    i_read    = 1'b1;
    i_address = 16'h3004;
    nd = 0;
    first_i = 0;
    maxc = 0;
    both = 0;
    for (int t = 1; t <= 17; t++) begin
      tick();
      lg[t] = {i_resp, d_resp};
      if (int'(dut.u_streak.cnt_q) > maxc) maxc = int'(dut.u_streak.cnt_q);
      if (i_resp && d_resp) both = 1;
      if (d_resp && first_i == 0) nd++;
      if (i_resp && first_i == 0) begin
        first_i = t;
        i_read = 1'b0;
      end
    end
    d_read = 1'b0;
    chk("fair_d_before_i", 16'(nd), 16'd4);
    chk("fair_i_tick", 16'(first_i), 16'd14);
    chk("fair_d4_tick", {14'd0, lg[11]}, 16'd1);
    chk("fair_d_resume", {14'd0, lg[17]}, 16'd1);
    chk("fair_max_streak", 16'(maxc), 16'd4);
    chk("fair_never_both", 16'(both), 16'd0);
    tick();

    // Stability: read+write treated as write; inputs toggle in BUSY_D.
    lat        = 4;
    pmem_rdata = 16'h7777;
    d_read     = 1'b1;
    d_write    = 1'b1;
    d_address  = 16'h4100;
    d_wdata    = 16'h1111;
    d_wmask    = 2'b11;
    tick();
    chk("stab_rw_is_write", {14'd0, pmem_read, pmem_write}, 16'd1);
    for (int c = 0; c < 3; c++) begin
      d_address = 16'($urandom);
      d_wdata   = ~d_address;
      d_wmask   = 2'b10;
      tick();
      chk("stab_addr", pmem_address, 16'h4100);
      chk("stab_wdata", pmem_wdata, 16'h1111);
    end
    tick();
    chk("stab_d_resp", {14'd0, i_resp, d_resp}, 16'd1);
    chk("stab_d_rdata", d_rdata, 16'h7777);
    d_read  = 1'b0;
    d_write = 1'b0;
    tick();

    // Stray pmem_resp in IDLE is ignored.
    force_resp = 1'b1;
    tick();
    tick();
    chk("stray_resp", {14'd0, i_resp, d_resp}, 16'd0);
    chk("stray_strobe", {14'd0, pmem_read, pmem_write}, 16'd0);
    force_resp = 1'b0;
    tick();

    // Reset in BUSY_I abandons the fetch.
    lat       = 10;
    i_read    = 1'b1;
    i_address = 16'h3006;
    tick();
    chk("mid_busy", {15'd0, pmem_read}, 16'd1);
    tick();
    reset_n = 1'b0;
    tick();
    chk("mid_strobe_drop", {15'd0, pmem_read}, 16'd0);
    chk("mid_no_resp", {15'd0, i_resp}, 16'd0);
    i_read  = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("mid_idle", 16'(dut.state_q), 16'(IDLE));
    tick();
    chk("mid_no_late_resp", {14'd0, i_resp, d_resp}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the pipelined LC-3b datapath and arbitrates its instruction-fetch port and MEM-stage data port onto a single physical memory port.
- Captures one request at a time and holds the downstream strobes stable until the memory responds.
- Returns read data and a one-cycle response pulse to the winning port.
- Data port has priority; a streak counter guarantees fetch forward progress.

Parameters:
- MAX_D_STREAK, 4: max consecutive D grants issued while an I request is pending before I must win.
- STREAK_W, 3: counter width; must satisfy 2^STREAK_W > MAX_D_STREAK.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- i_read  in  1  fetch read request, held until i_resp
- i_address  in  16  fetch address (lc3b_word)
- i_rdata  out  16  fetch read data, valid while i_resp=1
- i_resp  out  1  one-cycle fetch completion pulse
- d_read  in  1  data read request, held until d_resp
- d_write  in  1  data write request, held until d_resp
- d_address  in  16  data address
- d_wdata  in  16  write data
- d_wmask  in  2  byte enables; 11 = word, 01/10 = STB byte
- d_rdata  out  16  data read data, valid while d_resp=1
- d_resp  out  1  one-cycle data completion pulse
- pmem_read  out  1  downstream read strobe
- pmem_write  out  1  downstream write strobe
- pmem_address  out  16  downstream address
- pmem_wdata  out  16  downstream write data
- pmem_wmask  out  2  downstream byte enables
- pmem_rdata  in  16  downstream read data, valid with pmem_resp
- pmem_resp  in  1  downstream completion, any latency ≥1 cycle

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- Reset (reset_n=0 at an edge):
  - State goes to IDLE; streak counter = 0.
  - All outputs are 0: pmem strobes, resp pulses, rdata registers, address/wdata/wmask registers.
  - Reset mid-transaction abandons it; pmem strobes drop the next cycle and no resp is issued.
- IDLE grant rule, with d_req = d_read|d_write:
  - Grant D if d_req and (!i_read or streak < MAX_D_STREAK).
  - Otherwise grant I if i_read.
  - Otherwise stay in IDLE.
- On grant:
  - Latch address; for D also latch wdata, wmask and op.
  - d_read&d_write together is illegal; it is treated as a write.
  - An I grant latches wmask = 11.
  - Next state is BUSY_I or BUSY_D.
- Streak counter:
  - On a D grant with i_read=1: increment, saturating at MAX_D_STREAK.
  - On a D grant with i_read=0: clear to 0.
  - On an I grant: clear to 0.
- BUSY_x:
  - pmem_read/pmem_write are driven from the latched op, and pmem_address/wdata/wmask from the latched registers.
  - All of these are constant for the whole state.
  - Upstream input changes have no effect.
- BUSY_x with pmem_resp=1:
  - Capture pmem_rdata into the x rdata register (for writes too).
  - Go to DONE_x; strobes drop in DONE_x.
- DONE_x:
  - x_resp=1 for exactly one cycle; x_rdata holds the captured value until the next capture.
  - Next state is IDLE unconditionally, with no grant in DONE.
- Latency:
  - Request seen in IDLE at cycle 0; strobes asserted cycles 1..k.
  - pmem_resp arrives in cycle k; x_resp in cycle k+1.
  - Minimum is 2 cycles from grant edge to resp (k=1).
  - Back-to-back throughput is one transaction per k+2 cycles.
- Requester rules:
  - Hold the request stable until it samples resp=1, then deassert or change in the next cycle.
  - If a request drops during BUSY, the transaction still completes and resp still pulses.
- Exactly one of i_resp/d_resp may be high in any cycle; never both.
- pmem_resp in IDLE or DONE is ignored.

Decomposition:
- lc3b_types package:
  - lc3b_word (16 bits) and lc3b_mem_wmask (2 bits), already present.
  - Add an arb_state_t enum for the five states.
  - Add an arb_req_t struct {addr, wdata, wmask, read, write} used for the latched request.
- One sub-module, arb_streak_counter: saturating counter with inc, clr and at_max outputs.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with i_read=1 -> all outputs 0; after release, pmem_read=1, pmem_address=i_address one cycle later.
- Single fetch: i_read=1, i_address=0x3000, memory responds after 3 cycles with 0x1234 -> pmem_read high for 3 cycles, then i_resp=1 for one cycle with i_rdata=0x1234, then IDLE.
- Simultaneous: i_read and d_write (d_address=0x4000, d_wdata=0xBEEF, d_wmask=01) in the same cycle -> D served first with pmem_write=1, pmem_wmask=01; then I served; d_resp precedes i_resp.
- Fairness: d_read continuously requested and i_read held, memory latency 1 -> exactly 4 d_resp pulses, then i_resp, then D resumes; the counter never exceeds 4.
- Stability: during BUSY_D, toggle d_address and d_wdata every cycle -> pmem_address and pmem_wdata stay at the values latched at grant.
- Reset mid-op: reset_n=0 while in BUSY_I -> no i_resp; pmem_read=0 the next cycle; state is IDLE after reset release.
